// File: rtl/instr_stream_sequencer.sv
// instr_stream_sequencer: buffers a loaded program of up to DEPTH words and
// streams it to the core over a valid/ready handshake, pulsing done once the
// final word is consumed.
// Optional feature macro: INSTR_SEQ_LOOP_EN (continuous replay under loop_mode).
module instr_stream_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  loop_mode,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [CW-1:0]         instr_idx,
    output logic [CW-1:0]         count,
    output logic                  busy,
    output logic                  done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef INSTR_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    // loop_mode is still read below so the port stays part of the interface
    localparam bit LOOP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_count_nxt;
    logic [CW-1:0]         r_rd_ptr;
    logic [CW-1:0]         w_rd_ptr_nxt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_load_ready;
    logic w_load_acc;
    logic w_handshake;
    logic w_last;
    logic w_wrap;

    assign w_load_ready = (r_state == ST_IDLE) && (r_count < CW'(DEPTH)) && !start && !clear;
    assign w_load_acc   = load_valid && w_load_ready;
    assign w_handshake  = (r_state == ST_RUN) && instr_ready;
    assign w_last       = (r_rd_ptr == (r_count - CW'(1)));
    assign w_wrap       = LOOP_EN && loop_mode;

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, count and read-pointer decisions
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_rd_ptr_nxt = r_rd_ptr;
        case (r_state)
            ST_IDLE: begin
                if (clear) begin
                    w_count_nxt = '0;
                end else if (start && (r_count != '0)) begin
                    w_state_nxt  = ST_RUN;
                    w_rd_ptr_nxt = '0;
                end else if (w_load_acc) begin
                    w_count_nxt = r_count + CW'(1);
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // a handshake in the same cycle is dropped; pointer holds
                    w_state_nxt = ST_IDLE;
                end else if (w_handshake) begin
                    if (w_last) begin
                        w_rd_ptr_nxt = '0;
                        if (!w_wrap) begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_rd_ptr_nxt = r_rd_ptr + CW'(1);
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Count and read-pointer registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_count  <= w_count_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    // Program buffer write; contents are only observable after being loaded
    always_ff @(posedge clk) begin
        if (w_load_acc) begin
            r_mem[r_count[AW-1:0]] <= load_data;
        end
    end

    // Output decode
    always_comb begin
        instr_out   = '0;
        instr_valid = 1'b0;
        if (r_state == ST_RUN) begin
            instr_out   = r_mem[r_rd_ptr[AW-1:0]];
            instr_valid = 1'b1;
        end
        load_ready = w_load_ready;
        instr_idx  = r_rd_ptr;
        count      = r_count;
        busy       = (r_state == ST_RUN);
        done       = (r_state == ST_DONE);
    end

endmodule
